mcpu_param: RTL and testbench
=============================

# mcpu_param

Parametrised multi-cycle accumulator processor with the same accumulator architecture as the existing fixed 16-bit CPU. It adds configurable data and address widths, zero-test jump and halt opcodes, and a program-load/debug memory port. It also adds a run/halt control and optional indirect addressing. It sits at the top of the simple-processor design, holding its own unified instruction/data memory (2^ADDR_W words × DATA_W).

## Interface
- DATA_W, 16: accumulator, memory word and instruction width; must be ≥ 8.
- ADDR_W, 5: PC/MA width; memory depth is 2^ADDR_W; must be ≤ DATA_W-4.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- run  in  1  leave HALT; ignored in any other state.
- prog_we  in  1  memory write strobe; honoured only while halted.
- prog_addr  in  ADDR_W  program-load write address.
- prog_data  in  DATA_W  program-load write data.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  mem[dbg_addr], combinational.
- state  out  3  current FSM state encoding.
- pc  out  ADDR_W  program counter.
- ac  out  DATA_W  accumulator.
- carry  out  1  carry flag.
- halted  out  1  high when state == HALT.

## Operation
- Instruction format:
  - [DATA_W-1:DATA_W-3] opcode.
  - [DATA_W-4] AM, where 1 = indirect.
  - [ADDR_W-1:0] address; bits in between are ignored.
- Opcodes:
  - NOT 000: AC ← ~AC; carry unchanged.
  - ADC 001: {carry,AC} ← AC+M+carry.
  - JPA 010: PC ← target if AC ≠ 0.
  - INCA 011: {carry,AC} ← AC+1.
  - STA 100: M ← AC; AC and carry unchanged.
  - LDA 101: AC ← M; carry ← 0.
  - JPZ 110: PC ← target if AC == 0.
  - HLT 111: enter HALT.
- State encoding: HALT=0, FETCH=1, DECODE=2, IND=3, PTR=4, READ=5, EXEC=6. Codes 7 and above return to HALT.
- Transitions:
  - HALT: stays in HALT; run=1 → FETCH.
  - FETCH: IR ← mem[PC] → DECODE.
  - DECODE: PC ← PC+1, wrapping mod 2^ADDR_W; MA ← IR address field. Next state:
    - NOT, INCA → EXEC.
    - HLT → HALT.
    - JPA/JPZ with condition false → FETCH.
    - Otherwise, AM=1 → IND.
    - Otherwise, ADC/LDA → READ; STA/JPA/JPZ → EXEC.
  - IND: MD ← mem[MA] → PTR.
  - PTR: MA ← MD[ADDR_W-1:0]; ADC/LDA → READ, else → EXEC.
  - READ: MD ← mem[MA] → EXEC.
  - EXEC: performs the opcode (M = MD; jump target = MA) → FETCH.
- The jump condition is evaluated in DECODE, on AC at that cycle.
- Memory writes come from STA in EXEC, or from prog_we in HALT; the two are never both possible. Memory has no reset.
- In HALT, if prog_we and run are both asserted in the same cycle, the write takes effect and the following FETCH sees the new data.
- Reset in any state, including mid-instruction:
  - state=HALT; PC, AC, carry, IR, MA and MD = 0.
  - Memory contents are preserved.
  - Outputs after reset: state=0, pc=0, ac=0, carry=0, halted=1.
- Arithmetic is performed at DATA_W+1 bits; the MSB goes to carry. Address arithmetic wraps silently.

## Timing
- Cycles per instruction, counted from the FETCH cycle to the next FETCH:
  - NOT, INCA: 3.
  - JPA/JPZ not taken: 2. Taken direct: 3. Taken indirect: 5.
  - STA direct: 3. STA indirect: 5.
  - ADC/LDA direct: 4. ADC/LDA indirect: 6.
  - HLT: 2 cycles to reach HALT.
- run → FETCH on the next edge; the first instruction completes its FETCH one cycle later.
- prog_we writes on the clock edge; dbg_data reflects the write in the following cycle.

## Configuration
- MCPU_INDIRECT_EN defined: AM bit is honoured; IND and PTR states exist.
- MCPU_INDIRECT_EN undefined:
  - AM bit is ignored and every instruction uses direct addressing.
  - IND and PTR are never entered; their encodings are unreachable and go to HALT.
  - All cycle counts are the direct counts.

## Test plan
- Basic program (DATA_W=16, ADDR_W=5). mem[20]=0x0003; program 0:0xA014 (LDA 20), 1:0x2014 (ADC 20), 2:0x8015 (STA 21), 3:0xE000 (HLT); pulse run.
  - Required: halted after 13 cycles; ac=0x0006, carry=0, pc=4, mem[21]=0x0006.
- Carry chain. mem[20]=0xFFFF; program LDA 20, INCA, ADC 20, HLT.
  - After INCA: ac=0x0000, carry=1.
  - After ADC: ac=0x0000, carry=1.
- Indirect addressing (MCPU_INDIRECT_EN). mem[22]=0x0014, mem[20]=0x1234; program 0xB016 (LDA @22), 0xE000.
  - Required: ac=0x1234; LDA takes 6 cycles.
  - Without the macro: ac=mem[22]=0x0014, LDA takes 4 cycles.
- Jumps. ac=0; program 0:0x400A (JPA 10), 1:0xC00A (JPZ 10); mem[10]=0xE000.
  - Required: JPA not taken (pc=1 after 2 cycles); JPZ taken (pc=10); halted with pc=11.
- PC wrap and write protection. mem[31]=0x0000 (NOT), mem[0]=0xE000; start with pc=31.
  - Required: pc wraps to 0, then halted with ac=0xFFFF.
  - prog_we asserted during execution leaves memory unchanged.
- Reset mid-operation. Assert reset during EXEC of STA.
  - Required: next cycle state=0, pc=0, ac=0, carry=0, halted=1.
  - Target memory word unchanged; previously loaded program still readable via dbg_data.

Source files
------------

// File: rtl/mcpu_param.sv
// mcpu_param: parametrised multi-cycle accumulator processor.
// Unified instruction/data memory of 2^ADDR_W words x DATA_W bits, with a
// program-load write port (active only while halted) and a combinational
// debug read port.
// Optional feature macro: MCPU_INDIRECT_EN enables indirect addressing
// (the AM bit and the IND/PTR states). Without it, every instruction uses
// direct addressing and the IND/PTR encodings fall back to HALT.
module mcpu_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [2:0]        state,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ac,
    output logic              carry,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_IND    = 3'd3,
        S_PTR    = 3'd4,
        S_READ   = 3'd5,
        S_EXEC   = 3'd6
    } state_e;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_JPA  = 3'b010;
    localparam logic [2:0] OP_INCA = 3'b011;
    localparam logic [2:0] OP_STA  = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_JPZ  = 3'b110;
    localparam logic [2:0] OP_HLT  = 3'b111;

    localparam int DEPTH = 1 << ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ma_q, ma_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] md_q, md_d;
    logic              carry_q, carry_d;

    // Memory has no reset; contents survive a processor reset.
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [2:0]        op;
    logic              am;
    logic              ac_zero;
    logic              needs_read;
    logic [DATA_W:0]   adc_sum;
    logic [DATA_W:0]   inc_sum;

    // The middle instruction bits are don't-care operand padding.
    logic              unused_ir;
    assign unused_ir = ^ir_q;

    assign op         = ir_q[DATA_W-1 -: 3];
    assign ac_zero    = (ac_q == '0);
    assign needs_read = (op == OP_ADC) || (op == OP_LDA);

`ifdef MCPU_INDIRECT_EN
    assign am = ir_q[DATA_W-4];
`else
    assign am = 1'b0;
`endif

    // Arithmetic is done one bit wider so the MSB lands in carry.
    assign adc_sum = {1'b0, ac_q} + {1'b0, md_q} + (DATA_W+1)'(carry_q);
    assign inc_sum = {1'b0, ac_q} + (DATA_W+1)'(1);

    assign dbg_data = mem_q[dbg_addr];
    assign state    = state_q;
    assign pc       = pc_q;
    assign ac       = ac_q;
    assign carry    = carry_q;
    assign halted   = (state_q == S_HALT);

    // Next-state, datapath and memory-write control for the instruction FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ma_d      = ma_q;
        ac_d      = ac_q;
        ir_d      = ir_q;
        md_d      = md_q;
        carry_d   = carry_q;
        mem_we    = 1'b0;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;

        case (state_q)
            S_HALT: begin
                // Program-load writes land on the same edge run is taken,
                // so the first FETCH already sees them.
                if (prog_we) begin
                    mem_we = 1'b1;
                end
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                ir_d    = mem_q[pc_q];
                state_d = S_DECODE;
            end

            S_DECODE: begin
                pc_d = pc_q + ADDR_W'(1);
                ma_d = ir_q[ADDR_W-1:0];
                case (op)
                    OP_NOT, OP_INCA: state_d = S_EXEC;
                    OP_HLT:          state_d = S_HALT;
                    // Jump condition is judged here, on the current AC.
                    OP_JPA: begin
                        if (ac_zero)  state_d = S_FETCH;
                        else if (am)  state_d = S_IND;
                        else          state_d = S_EXEC;
                    end
                    OP_JPZ: begin
                        if (!ac_zero) state_d = S_FETCH;
                        else if (am)  state_d = S_IND;
                        else          state_d = S_EXEC;
                    end
                    OP_ADC, OP_LDA: state_d = am ? S_IND : S_READ;
                    default:        state_d = am ? S_IND : S_EXEC;
                endcase
            end

`ifdef MCPU_INDIRECT_EN
            S_IND: begin
                md_d    = mem_q[ma_q];
                state_d = S_PTR;
            end

            S_PTR: begin
                ma_d    = md_q[ADDR_W-1:0];
                state_d = needs_read ? S_READ : S_EXEC;
            end
`endif

            S_READ: begin
                md_d    = mem_q[ma_q];
                state_d = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_NOT:  ac_d = ~ac_q;
                    OP_ADC:  {carry_d, ac_d} = adc_sum;
                    OP_INCA: {carry_d, ac_d} = inc_sum;
                    OP_LDA: begin
                        ac_d    = md_q;
                        carry_d = 1'b0;
                    end
                    OP_STA: begin
                        mem_we    = 1'b1;
                        mem_waddr = ma_q;
                        mem_wdata = ac_q;
                    end
                    // Only taken jumps reach EXEC.
                    OP_JPA, OP_JPZ: pc_d = ma_q;
                    default: ;
                endcase
            end

            // Unused encodings (and IND/PTR when indirect is off) park in HALT.
            default: state_d = S_HALT;
        endcase
    end

    // Processor registers; reset clears everything except memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HALT;
            pc_q    <= '0;
            ma_q    <= '0;
            ac_q    <= '0;
            ir_q    <= '0;
            md_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ma_q    <= ma_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
            md_q    <= md_d;
            carry_q <= carry_d;
        end
    end

    // Memory write port; a reset edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mcpu_param.sv
// Directed testbench for mcpu_param (DATA_W=16, ADDR_W=5).
// Expectations switch on MCPU_INDIRECT_EN for the indirect-addressing case.
module tb_mcpu_param;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              run;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ac;
    logic              carry;
    logic              halted;

    int total;
    int bad;

    mcpu_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .state     (state),
        .pc        (pc),
        .ac        (ac),
        .carry     (carry),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step(1);
        prog_we   = 1'b0;
    endtask

    task automatic go();
        run = 1'b1;
        step(1);
        run = 1'b0;
    endtask

    task automatic peek(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    logic [DATA_W-1:0] rd;

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        run       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        dbg_addr  = '0;
        step(2);
        chk("rst_state",  32'(state),  32'd0);
        chk("rst_pc",     32'(pc),     32'd0);
        chk("rst_ac",     32'(ac),     32'd0);
        chk("rst_carry",  32'(carry),  32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        reset = 1'b0;

        // Basic program: LDA 20; ADC 20; STA 21; HLT
        load(5'd20, 16'h0003);
        load(5'd21, 16'h0000);
        load(5'd0,  16'hA014);
        load(5'd1,  16'h2014);
        load(5'd2,  16'h8015);
        load(5'd3,  16'hE000);
        go();
        step(12);
        chk("basic_not_yet_halted", 32'(halted), 32'd0);
        step(1);
        chk("basic_halted", 32'(halted), 32'd1);
        chk("basic_ac",     32'(ac),     32'h0006);
        chk("basic_carry",  32'(carry),  32'd0);
        chk("basic_pc",     32'(pc),     32'd4);
        peek(5'd21, rd);
        chk("basic_mem21",  32'(rd),     32'h0006);

        // Carry chain: LDA 20 (FFFF); INCA; ADC 20; HLT
        do_reset();
        load(5'd20, 16'hFFFF);
        load(5'd0,  16'hA014);
        load(5'd1,  16'h6000);
        load(5'd2,  16'h2014);
        load(5'd3,  16'hE000);
        go();
        step(7);
        chk("inca_state", 32'(state), 32'd1);
        chk("inca_ac",    32'(ac),    32'h0000);
        chk("inca_carry", 32'(carry), 32'd1);
        step(4);
        chk("adc_ac",     32'(ac),    32'h0000);
        chk("adc_carry",  32'(carry), 32'd1);
        step(2);
        chk("carry_halted", 32'(halted), 32'd1);

        // Indirect: LDA @22 with mem[22]=20, mem[20]=1234
        do_reset();
        load(5'd22, 16'h0014);
        load(5'd20, 16'h1234);
        load(5'd0,  16'hB016);
        load(5'd1,  16'hE000);
        go();
`ifdef MCPU_INDIRECT_EN
        step(5);
        chk("ind_not_done", 32'(state), 32'd6);
        step(1);
        chk("ind_state", 32'(state), 32'd1);
        chk("ind_ac",    32'(ac),    32'h1234);
`else
        step(3);
        chk("dir_not_done", 32'(state), 32'd6);
        step(1);
        chk("dir_state", 32'(state), 32'd1);
        chk("dir_ac",    32'(ac),    32'h0014);
`endif
        chk("ind_pc", 32'(pc), 32'd1);

        // Jumps with ac=0: JPA 10 not taken, JPZ 10 taken, HLT at 10
        do_reset();
        load(5'd0,  16'h400A);
        load(5'd1,  16'hC00A);
        load(5'd10, 16'hE000);
        go();
        step(2);
        chk("jpa_nt_pc",    32'(pc),    32'd1);
        chk("jpa_nt_state", 32'(state), 32'd1);
        step(3);
        chk("jpz_t_pc",     32'(pc),    32'd10);
        step(2);
        chk("jmp_halted",   32'(halted), 32'd1);
        chk("jmp_pc",       32'(pc),     32'd11);

        // PC wrap: JPZ 31 -> NOT at 31 -> wraps to 0 -> JPZ not taken -> HLT
        // prog_we held high while running must not write memory.
        do_reset();
        load(5'd0,  16'hC01F);
        load(5'd31, 16'h0000);
        load(5'd1,  16'hE000);
        load(5'd5,  16'h0BAD);
        go();
        prog_we   = 1'b1;
        prog_addr = 5'd5;
        prog_data = 16'h1234;
        step(3);
        chk("wrap_pc31", 32'(pc), 32'd31);
        step(2);
        chk("wrap_pc0",  32'(pc), 32'd0);
        step(1);
        prog_we = 1'b0;
        chk("wrap_not_ac", 32'(ac), 32'hFFFF);
        step(4);
        chk("wrap_halted", 32'(halted), 32'd1);
        chk("wrap_pc_end", 32'(pc),     32'd2);
        chk("wrap_ac_end", 32'(ac),     32'hFFFF);
        peek(5'd5, rd);
        chk("wprot_mem5", 32'(rd), 32'h0BAD);

        // Reset in EXEC of STA 25
        do_reset();
        load(5'd20, 16'h5555);
        load(5'd25, 16'h00AA);
        load(5'd0,  16'hA014);
        load(5'd1,  16'h8019);
        go();
        step(6);
        chk("sta_in_exec", 32'(state), 32'd6);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_rst_state",  32'(state),  32'd0);
        chk("mid_rst_pc",     32'(pc),     32'd0);
        chk("mid_rst_ac",     32'(ac),     32'd0);
        chk("mid_rst_carry",  32'(carry),  32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd1);
        peek(5'd25, rd);
        chk("mid_rst_mem25", 32'(rd), 32'h00AA);
        peek(5'd0, rd);
        chk("mid_rst_mem0",  32'(rd), 32'hA014);

        // prog_we and run in the same cycle: FETCH sees the new word (HLT)
        prog_we   = 1'b1;
        prog_addr = 5'd0;
        prog_data = 16'hE000;
        run       = 1'b1;
        step(1);
        prog_we = 1'b0;
        run     = 1'b0;
        chk("ld_run_state", 32'(state), 32'd1);
        step(2);
        chk("ld_run_halted", 32'(halted), 32'd1);
        chk("ld_run_pc",     32'(pc),     32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
